// File: rtl/mcmult_mac_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcmult_pkg
// Description : Shared definitions for the mcmult accumulator stage.
//               - Multiplier mode encodings.
//               - Per-mode latencies and product sign-bit positions.
//               - FSM state type.
//               - Helper that maps a mode to its latency.
// Revision    : 1.0 - initial release
// ============================================================================
package mcmult_pkg;

    // Mode encodings. Bit 1 alone selects 8x8, so 2'b11 decodes the same as
    // MODE_8X8 (the "1x" pattern).
    localparam logic [1:0] MODE_4X4 = 2'b00;
    localparam logic [1:0] MODE_4X8 = 2'b01;
    localparam logic [1:0] MODE_8X8 = 2'b10;

    // Cycles from start to a final product (the start cycle counts as one).
    localparam logic [2:0] LAT_4X4 = 3'd1;
    localparam logic [2:0] LAT_4X8 = 3'd2;
    localparam logic [2:0] LAT_8X8 = 3'd4;

    // Sign-bit index of the product for each mode.
    localparam int SIGN_4X4 = 9;
    localparam int SIGN_4X8 = 12;
    localparam int SIGN_8X8 = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [2:0] mode_lat(input logic [1:0] m);
        logic [2:0] lat;
        if (m[1])               lat = LAT_8X8;
        else if (m == MODE_4X8) lat = LAT_4X8;
        else                    lat = LAT_4X4;
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcmult_mac_acc_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : mac_sat_add
// Description : Combinational accumulate step.
//               - Sign-extends the product from the mode's sign bit.
//               - Adds it to the accumulator operand at ACC_W+1 bits.
//               - Flags signed overflow and optionally clamps.
//               When i_accumulate is 0 the accumulator operand is forced to
//               zero, which turns the add into a load.
// Ports       : i_acc        accumulator operand (already cleared if needed)
//               i_prod       raw multiplier product
//               i_mode       mode selecting the product's sign bit
//               i_accumulate 1 add, 0 load
//               o_sum        resulting accumulator value
//               o_ovf        signed overflow occurred
// Revision    : 1.0 - initial release
// ============================================================================
module mac_sat_add #(
    parameter int PROD_W = 18,
    parameter int ACC_W  = 32,
    parameter int SAT    = 1
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    input  logic [1:0]        i_mode,
    input  logic              i_accumulate,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);
    import mcmult_pkg::*;

    localparam logic [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] w_sext;
    logic [ACC_W-1:0] w_a;
    logic [ACC_W:0]   w_sum_ext;

    always_comb begin
        w_sext = '0;
        if (i_mode[1]) begin
            w_sext = {{(ACC_W-SIGN_8X8-1){i_prod[SIGN_8X8]}}, i_prod[SIGN_8X8:0]};
        end else if (i_mode[0]) begin
            w_sext = {{(ACC_W-SIGN_4X8-1){i_prod[SIGN_4X8]}}, i_prod[SIGN_4X8:0]};
        end else begin
            w_sext = {{(ACC_W-SIGN_4X4-1){i_prod[SIGN_4X4]}}, i_prod[SIGN_4X4:0]};
        end
    end

    assign w_a       = i_accumulate ? i_acc : '0;
    assign w_sum_ext = {w_a[ACC_W-1], w_a} + {w_sext[ACC_W-1], w_sext};

    // The two top bits of the widened sum disagree exactly when both operands
    // share a sign and the truncated result does not.
    assign o_ovf = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];

    always_comb begin
        o_sum = w_sum_ext[ACC_W-1:0];
        if (SAT != 0 && o_ovf) begin
            o_sum = w_a[ACC_W-1] ? C_MIN : C_MAX;
        end
    end

    // Product bits above the widest sign bit carry no information.
    generate
        if (PROD_W > SIGN_8X8 + 1) begin : g_unused_prod
            logic w_unused_hi;
            assign w_unused_hi = ^i_prod[PROD_W-1:SIGN_8X8+1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mcmult_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : mcmult_mac_acc
// Description : Accumulator stage downstream of the multi-cycle multiplier.
//               - Follows each start pulse for the mode's latency.
//               - Captures the combinational product in its final cycle.
//               - Accumulates or loads it into a signed ACC_W register.
//               Busy back-pressures the operand issuer while an op is in
//               flight.
// Ports       : clk, rst     clock, synchronous active-high reset
//               start        start pulse shared with the multiplier
//               mode         00 4x4, 01 4x8, 1x 8x8 (latched on start)
//               accumulate   1 add, 0 load (latched on start)
//               acc_clr      synchronous accumulator/flag clear
//               prod_in      multiplier result
//               acc_out      accumulator value
//               acc_valid    pulse after a completed op updated acc_out
//               busy         op in flight, start not accepted
//               err_start    sticky: start seen while busy
//               sat_flag     sticky: overflow occurred
//               op_count     completed ops (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module mcmult_mac_acc #(
    parameter int PROD_W = 18,
    parameter int ACC_W  = 32,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              accumulate,
    input  logic              acc_clr,
    input  logic [PROD_W-1:0] prod_in,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    output logic              busy,
    output logic              err_start,
    output logic              sat_flag,
    output logic [15:0]       op_count
);
    import mcmult_pkg::*;

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [1:0]       r_mode;
    logic             r_accum;
    logic [ACC_W-1:0] r_acc;
    logic             r_valid;
    logic             r_err;
    logic             r_sat;
    logic [15:0]      r_count;

    logic             w_accept;
    logic [2:0]       w_start_lat;
    logic [2:0]       w_run_lat;
    logic             w_cap_idle;
    logic             w_cap_run;
    logic             w_capture;
    logic [1:0]       w_op_mode;
    logic             w_op_accum;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;

    assign w_accept    = start && (r_state == ST_IDLE);
    assign w_start_lat = mode_lat(mode);
    assign w_run_lat   = mode_lat(r_mode);

    // A 1-cycle op completes in its own start cycle, straight from IDLE.
    assign w_cap_idle = w_accept && (w_start_lat == LAT_4X4);
    assign w_cap_run  = (r_state == ST_RUN) && (r_cnt == w_run_lat - 3'd1);
    assign w_capture  = w_cap_idle || w_cap_run;

    // Live inputs for a same-cycle capture, latched copies while running.
    assign w_op_mode  = (r_state == ST_RUN) ? r_mode  : mode;
    assign w_op_accum = (r_state == ST_RUN) ? r_accum : accumulate;

    // A clear coinciding with a capture acts first, so the op sees zero.
    assign w_base = acc_clr ? '0 : r_acc;

    mac_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .SAT    (SAT)
    ) u_sat_add (
        .i_acc        (w_base),
        .i_prod       (prod_in),
        .i_mode       (w_op_mode),
        .i_accumulate (w_op_accum),
        .o_sum        (w_sum),
        .o_ovf        (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_mode  <= 2'b00;
            r_accum <= 1'b0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_sat   <= 1'b0;
            r_count <= 16'd0;
        end else begin
            r_valid <= w_capture;

            if (w_capture) begin
                r_acc   <= w_sum;
                r_count <= r_count + 16'd1;
            end else if (acc_clr) begin
                r_acc <= '0;
            end

            // A fresh error in the same cycle as a clear is kept.
            r_err <= (r_err & ~acc_clr) | (start & (r_state == ST_RUN));
            r_sat <= (r_sat & ~acc_clr) | (w_capture & w_ovf);

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mode  <= mode;
                        r_accum <= accumulate;
                        if (w_start_lat != LAT_4X4) begin
                            r_state <= ST_RUN;
                            r_cnt   <= 3'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_cap_run) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign acc_out   = r_acc;
    assign acc_valid = r_valid;
    assign busy      = (r_state == ST_RUN);
    assign err_start = r_err;
    assign sat_flag  = r_sat;
    assign op_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mcmult_mac_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcmult_mac_acc
// Description : Self-checking bench for mcmult_mac_acc. Four instances share
//               the stimulus: 32-bit and 20-bit accumulators, each with
//               saturation on and off. A transaction-level arithmetic model
//               predicts every instance's results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcmult_mac_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        accumulate;
    logic        acc_clr;
    logic [17:0] prod_in;

    logic [31:0] acc0, acc1;
    logic [19:0] acc2, acc3;
    logic [3:0]  valid_v, busy_v, err_v, sat_v;
    logic [3:0][15:0] cnt_v;

    int n_checks = 0;
    int n_fail   = 0;

    longint      m_acc [4];
    bit          m_sat [4];
    bit          m_err;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    mcmult_mac_acc #(.PROD_W(18), .ACC_W(32), .SAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .accumulate(accumulate),
        .acc_clr(acc_clr), .prod_in(prod_in), .acc_out(acc0), .acc_valid(valid_v[0]),
        .busy(busy_v[0]), .err_start(err_v[0]), .sat_flag(sat_v[0]), .op_count(cnt_v[0]));

    mcmult_mac_acc #(.PROD_W(18), .ACC_W(32), .SAT(0)) dut_w32 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .accumulate(accumulate),
        .acc_clr(acc_clr), .prod_in(prod_in), .acc_out(acc1), .acc_valid(valid_v[1]),
        .busy(busy_v[1]), .err_start(err_v[1]), .sat_flag(sat_v[1]), .op_count(cnt_v[1]));

    mcmult_mac_acc #(.PROD_W(18), .ACC_W(20), .SAT(1)) dut_s20 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .accumulate(accumulate),
        .acc_clr(acc_clr), .prod_in(prod_in), .acc_out(acc2), .acc_valid(valid_v[2]),
        .busy(busy_v[2]), .err_start(err_v[2]), .sat_flag(sat_v[2]), .op_count(cnt_v[2]));

    mcmult_mac_acc #(.PROD_W(18), .ACC_W(20), .SAT(0)) dut_w20 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .accumulate(accumulate),
        .acc_clr(acc_clr), .prod_in(prod_in), .acc_out(acc3), .acc_valid(valid_v[3]),
        .busy(busy_v[3]), .err_start(err_v[3]), .sat_flag(sat_v[3]), .op_count(cnt_v[3]));

    // ---------------- reference model ----------------
    function automatic int width_of(input int i);
        return (i < 2) ? 32 : 20;
    endfunction

    function automatic bit sat_of(input int i);
        return (i % 2) == 0;
    endfunction

    function automatic int lat(input logic [1:0] m);
        return m[1] ? 4 : (m[0] ? 2 : 1);
    endfunction

    function automatic int sign_bit(input logic [1:0] m);
        return m[1] ? 15 : (m[0] ? 12 : 9);
    endfunction

    function automatic longint sext(input logic [17:0] p, input logic [1:0] m);
        int     sb;
        longint v;
        sb = sign_bit(m);
        v  = longint'(p) & ((longint'(1) << (sb + 1)) - 1);
        if (p[sb]) v = v - (longint'(1) << (sb + 1));
        return v;
    endfunction

    function automatic longint step(input longint acc, input longint p, input bit acc_en,
                                    input bit clr, input int w, input bit sat, output bit ovf);
        longint s, mx, mn, span;
        span = longint'(1) << w;
        mx   = span / 2 - 1;
        mn   = -(span / 2);
        s    = p + ((acc_en && !clr) ? acc : 64'sd0);
        ovf  = 1'b0;
        if (s > mx) begin
            ovf = 1'b1;
            s   = sat ? mx : s - span;
        end else if (s < mn) begin
            ovf = 1'b1;
            s   = sat ? mn : s + span;
        end
        return s;
    endfunction

    function automatic logic [31:0] obs_acc(input int i);
        case (i)
            0:       return acc0;
            1:       return acc1;
            2:       return {12'd0, acc2};
            default: return {12'd0, acc3};
        endcase
    endfunction

    function automatic logic [31:0] exp_acc(input int i);
        longint mk;
        mk = (longint'(1) << width_of(i)) - 1;
        return 32'(m_acc[i] & mk);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0;
            m_sat[i] = 1'b0;
        end
        m_err = 1'b0;
        m_cnt = 16'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenario drivers ----------------
    // Idle cycle (optionally with acc_clr); the following cycle must show no
    // acc_valid and the model's current state.
    task automatic idle_cycle(input bit clr);
        start   = 1'b0;
        acc_clr = clr;
        prod_in = 18'($urandom);
        tick();
        acc_clr = 1'b0;
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                m_acc[i] = 0;
                m_sat[i] = 1'b0;
            end
            m_err = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (valid_v[i] !== 1'b0 || obs_acc(i) !== exp_acc(i) || sat_v[i] !== m_sat[i] ||
                err_v[i] !== m_err || cnt_v[i] !== m_cnt) begin
                n_fail++;
                $display("FAIL idle[%0d]: valid=%b acc=%h sat=%b err=%b cnt=%0d, required valid=0 acc=%h sat=%b err=%b cnt=%0d",
                         i, valid_v[i], obs_acc(i), sat_v[i], err_v[i], cnt_v[i],
                         exp_acc(i), m_sat[i], m_err, m_cnt);
            end
        end
    endtask

    // One complete op starting in the current cycle. Inputs that must be
    // ignored (mode/accumulate while busy, product bits above the sign bit,
    // prod_in outside the capture cycle) are randomised.
    task automatic run_op(input logic [1:0] md, input bit acc_en, input logic [15:0] pv,
                          input bit clr, input bit restart);
        int          L;
        logic [17:0] mask;
        logic [17:0] pfull;
        bit          ovf;
        L     = lat(md);
        mask  = (18'd1 << (sign_bit(md) + 1)) - 18'd1;
        pfull = (18'($urandom) & ~mask) | ({2'b00, pv} & mask);

        n_checks++;
        if (busy_v !== 4'b0000) begin
            n_fail++;
            $display("FAIL busy_at_start: busy=%b, required 0000", busy_v);
        end
        start      = 1'b1;
        mode       = md;
        accumulate = acc_en;
        acc_clr    = (L == 1) ? clr : 1'b0;
        prod_in    = (L == 1) ? pfull : 18'($urandom);
        tick();
        start   = 1'b0;
        acc_clr = 1'b0;
        for (int k = 1; k < L; k++) begin
            n_checks++;
            if (busy_v !== 4'b1111 || valid_v !== 4'b0000) begin
                n_fail++;
                $display("FAIL in_flight k=%0d: busy=%b valid=%b, required busy=1111 valid=0000",
                         k, busy_v, valid_v);
            end
            start      = restart && (k == 1);
            mode       = 2'($urandom);
            accumulate = 1'($urandom);
            prod_in    = (k == L - 1) ? pfull : 18'($urandom);
            acc_clr    = (k == L - 1) ? clr : 1'b0;
            tick();
        end
        start   = 1'b0;
        acc_clr = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (clr) m_sat[i] = 1'b0;
            m_acc[i] = step(m_acc[i], sext(pfull, md), acc_en, clr, width_of(i), sat_of(i), ovf);
            if (ovf) m_sat[i] = 1'b1;
        end
        if (clr) m_err = 1'b0;
        if (restart && L > 1) m_err = 1'b1;
        m_cnt = m_cnt + 16'd1;

        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (valid_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || obs_acc(i) !== exp_acc(i) ||
                sat_v[i] !== m_sat[i] || err_v[i] !== m_err || cnt_v[i] !== m_cnt) begin
                n_fail++;
                $display("FAIL op_done[%0d] mode=%b: valid=%b busy=%b acc=%h sat=%b err=%b cnt=%0d, required valid=1 busy=0 acc=%h sat=%b err=%b cnt=%0d",
                         i, md, valid_v[i], busy_v[i], obs_acc(i), sat_v[i], err_v[i], cnt_v[i],
                         exp_acc(i), m_sat[i], m_err, m_cnt);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'b00; accumulate = 1'b0; acc_clr = 1'b0; prod_in = '0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        n_checks++;
        if (acc0 !== 32'd0 || acc2 !== 20'd0 || valid_v !== 4'b0 || busy_v !== 4'b0 ||
            err_v !== 4'b0 || sat_v !== 4'b0 || cnt_v[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: acc=%h valid=%b busy=%b err=%b sat=%b cnt=%0d, required all zero",
                     acc0, valid_v, busy_v, err_v, sat_v, cnt_v[0]);
        end
    endtask

    task automatic test_mode00_back_to_back();
        run_op(2'b00, 1'b0, 16'd5, 1'b0, 1'b0);
        run_op(2'b00, 1'b1, 16'h03FF, 1'b0, 1'b0);
        n_checks++;
        if (acc0 !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_first: acc=%0d, required 4", acc0);
        end
        run_op(2'b00, 1'b1, 16'h0002, 1'b0, 1'b0);
        n_checks++;
        if (acc0 !== 32'd6 || valid_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: acc=%0d valid=%b, required 6 valid=1", acc0, valid_v[0]);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_mode1x_timing();
        run_op(2'b10, 1'b0, 16'h8000, 1'b0, 1'b0);
        n_checks++;
        if (acc0 !== 32'hFFFF8000) begin
            n_fail++;
            $display("FAIL mode1x_load: acc=%h, required ffff8000", acc0);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_start_while_busy();
        run_op(2'b01, 1'b1, 16'h0123, 1'b0, 1'b1);
        n_checks++;
        if (err_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_start: err=%b, required 1", err_v[0]);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_saturation();
        idle_cycle(1'b1);
        run_op(2'b10, 1'b0, 16'h7FFF, 1'b0, 1'b0);
        for (int n = 0; n < 15; n++) run_op(2'b10, 1'b1, 16'h7FFF, 1'b0, 1'b0);
        n_checks++;
        if (acc2 !== 20'h7FFF0 || acc3 !== 20'h7FFF0) begin
            n_fail++;
            $display("FAIL sat_preload: acc=%h/%h, required 7fff0", acc2, acc3);
        end
        run_op(2'b01, 1'b1, 16'h0100, 1'b0, 1'b0);
        n_checks++;
        if (acc2 !== 20'h7FFFF || sat_v[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_clamp: acc=%h sat=%b, required 7ffff sat=1", acc2, sat_v[2]);
        end
        n_checks++;
        if (acc3 !== 20'h800F0 || sat_v[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_wrap: acc=%h sat=%b, required 800f0 sat=1", acc3, sat_v[3]);
        end
    endtask

    task automatic test_clr_at_capture();
        // Leave err_start set so the clear has something to drop.
        run_op(2'b01, 1'b1, 16'h0001, 1'b0, 1'b1);
        run_op(2'b11, 1'b1, 16'h0010, 1'b1, 1'b0);
        n_checks++;
        if (acc0 !== 32'd16 || acc2 !== 20'd16 || err_v !== 4'b0 || sat_v !== 4'b0) begin
            n_fail++;
            $display("FAIL clr_capture: acc=%h/%h err=%b sat=%b, required 16 err=0 sat=0",
                     acc0, acc2, err_v, sat_v);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_reset_mid_op();
        start = 1'b1; mode = 2'b10; accumulate = 1'b1; prod_in = 18'($urandom);
        tick();                     // t1
        start = 1'b0;
        tick();                     // t2
        rst = 1'b1;
        tick();                     // t3
        rst = 1'b0;
        model_reset();
        n_checks++;
        if (acc0 !== 32'd0 || acc3 !== 20'd0 || valid_v !== 4'b0 || busy_v !== 4'b0 ||
            err_v !== 4'b0 || sat_v !== 4'b0 || cnt_v[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: acc=%h valid=%b busy=%b err=%b sat=%b cnt=%0d, required all zero",
                     acc0, valid_v, busy_v, err_v, sat_v, cnt_v[1]);
        end
        tick();                     // t4
        n_checks++;
        if (valid_v !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_abandon: valid=%b, required 0000", valid_v);
        end
        run_op(2'b10, 1'b1, 16'h1234, 1'b0, 1'b0);
        idle_cycle(1'b0);
    endtask

    task automatic test_random();
        logic [1:0] md;
        bit         clr, rs;
        for (int n = 0; n < 60; n++) begin
            md  = 2'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            rs  = (lat(md) > 1) && !clr && ($urandom_range(0, 3) == 0);
            run_op(md, $urandom_range(0, 3) != 0, 16'($urandom), clr, rs);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle($urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_mode00_back_to_back();
        test_mode1x_timing();
        test_start_while_busy();
        test_saturation();
        test_clr_at_capture();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
